ram_loader: RTL

Boot-time serial loader that writes program images into the 32K×8 byte RAM. It consumes a byte stream from the UART receiver, parses a framed load command, and drives the RAM's `en`/`wr`/`addr`/`din` write port directly. While `busy` is high the top level routes the RAM port to this block and holds the CPU in reset.

---
 rtl/loader_pkg.sv | 20 ++
 rtl/loader_timer.sv | 30 +++
 rtl/ram_loader.sv | 129 ++++++++++++
 3 files changed

// File: rtl/loader_pkg.sv
// Shared definitions for the boot-time serial RAM loader.
// RAM geometry matches the 32Kx8 program RAM.
package loader_pkg;

  localparam int ADDR_W = 15;
  localparam int DATA_W = 8;

  localparam logic [DATA_W-1:0] SYNC_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR_HI,
    S_ADDR_LO,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_CSUM
  } state_t;

endpackage

// File: rtl/loader_timer.sv
// Inter-byte watchdog: counts idle cycles while a frame is open.
// A kick in the expiry cycle suppresses the expiry.
module loader_timer #(
  parameter int TIMEOUT = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic kick,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] LIMIT = W'(TIMEOUT);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!run || kick) begin
      cnt <= '0;
    end else if (cnt != LIMIT) begin
      cnt <= cnt + W'(1);
    end
  end

  assign expired = run && !kick && (cnt == LIMIT);

endmodule

// File: rtl/ram_loader.sv
// Parses SYNC/ADDR/LEN/DATA/CSUM frames from the UART
// and writes the payload straight into the program RAM.
module ram_loader
  import loader_pkg::*;
#(
  parameter logic [DATA_W-1:0] SYNC    = SYNC_DEFAULT,
  parameter int                TIMEOUT = 1000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_valid,
  input  logic [DATA_W-1:0] rx_data,
  output logic              ram_en,
  output logic              ram_wr,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_t            state, state_n;
  logic [ADDR_W-1:0] addr, addr_n;
  logic [15:0]       len, len_n;
  logic [7:0]        sum, sum_n, sum_add;
  logic              en_n, done_n, err_n;
  logic [ADDR_W-1:0] waddr_n;
  logic [DATA_W-1:0] din_n;
  logic              expired;

  loader_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .run    (state != S_IDLE),
    .kick   (rx_valid),
    .expired(expired)
  );

  assign sum_add = sum + rx_data;

  always_comb begin
    state_n = state;
    addr_n  = addr;
    len_n   = len;
    sum_n   = sum;
    en_n    = 1'b0;
    done_n  = 1'b0;
    err_n   = 1'b0;
    waddr_n = ram_addr;
    din_n   = ram_din;
    if (expired) begin
      err_n   = 1'b1;
      state_n = S_IDLE;
    end else if (rx_valid) begin
      sum_n = sum_add;
      unique case (state)
        S_IDLE: begin
          sum_n = 8'h00;
          if (rx_data == SYNC) state_n = S_ADDR_HI;
        end
        S_ADDR_HI: begin
          if (rx_data[7]) begin
            err_n   = 1'b1;
            state_n = S_IDLE;
          end else begin
            addr_n[14:8] = rx_data[6:0];
            state_n      = S_ADDR_LO;
          end
        end
        S_ADDR_LO: begin
          addr_n[7:0] = rx_data;
          state_n     = S_LEN_HI;
        end
        S_LEN_HI: begin
          len_n[15:8] = rx_data;
          state_n     = S_LEN_LO;
        end
        S_LEN_LO: begin
          len_n   = {len[15:8], rx_data};
          state_n = ({len[15:8], rx_data} == 16'd0) ? S_CSUM : S_DATA;
        end
        S_DATA: begin
          en_n    = 1'b1;
          waddr_n = addr;
          din_n   = rx_data;
          addr_n  = addr + ADDR_W'(1);
          len_n   = len - 16'd1;
          if (len == 16'd1) state_n = S_CSUM;
        end
        S_CSUM: begin
          done_n  = (sum_add == 8'h00);
          err_n   = (sum_add != 8'h00);
          state_n = S_IDLE;
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      addr     <= '0;
      len      <= '0;
      sum      <= '0;
      ram_en   <= 1'b0;
      ram_addr <= '0;
      ram_din  <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_n;
      addr     <= addr_n;
      len      <= len_n;
      sum      <= sum_n;
      ram_en   <= en_n;
      ram_addr <= waddr_n;
      ram_din  <= din_n;
      done     <= done_n;
      err      <= err_n;
    end
  end

  assign ram_wr = ram_en;
  assign busy   = (state != S_IDLE);

endmodule
